// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared types and helpers for the bit-serial adder sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    localparam int unsigned DEF_WORDWIDTH = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } seq_state_t;

    // Result record at the default word width; the top declares its own
    // width-parameterised copy with the same field order.
    typedef struct packed {
        logic                     cout;
        logic [DEF_WORDWIDTH-1:0] sum;
    } add_res_t;

    // Adder period in clocks: one done pulse every WORDWIDTH+3 cycles.
    function automatic int unsigned add_period(input int unsigned width);
        return width + 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : serial_seq_fifo
// Description : Generic synchronous FIFO with occupancy count output.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok_w;
    logic             pop_ok_w;

    // A full FIFO refuses a push even when a pop frees a slot this cycle.
    assign push_ok_w = push_i && (count_q != CW'(DEPTH));
    assign pop_ok_w  = pop_i  && (count_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_w) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok_w) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_ok_w) - CW'(pop_ok_w);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_w) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/serial_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_sequencer
// Description : Feeds operand pairs to a free-running bit-serial adder and
//               collects its results in order. Optional sticky overflow flag
//               enabled by defining SERIAL_ADD_SEQ_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int WORDWIDTH = 8,
    parameter int OP_DEPTH  = 2,
    parameter int RES_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [WORDWIDTH-1:0] op_a,
    input  logic [WORDWIDTH-1:0] op_b,
    output logic [WORDWIDTH-1:0] add_a,
    output logic [WORDWIDTH-1:0] add_b,
    input  logic                 add_done,
    input  logic [WORDWIDTH-1:0] add_sum,
    input  logic                 add_cout,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WORDWIDTH-1:0] res_sum,
    output logic                 res_cout,
    output logic                 busy
`ifdef SERIAL_ADD_SEQ_OVF_EN
    ,
    input  logic                 ovf_clr,
    output logic                 ovf_sticky
`endif
);

    localparam int OCW = $clog2(OP_DEPTH) + 1;
    localparam int RCW = $clog2(RES_DEPTH) + 1;

    typedef struct packed {
        logic                 cout;
        logic [WORDWIDTH-1:0] sum;
    } res_rec_t;

    seq_state_t             state_q;
    logic [OCW-1:0]         op_count_w;
    logic [2*WORDWIDTH-1:0] op_head_w;
    logic [RCW-1:0]         res_count_w;
    logic [RCW-1:0]         res_next_w;
    res_rec_t               res_head_w;
    res_rec_t               res_wdata_w;
    logic                   op_push_w;
    logic                   res_pop_w;
    logic                   capture_w;
    logic                   issue_w;

    assign op_ready  = (op_count_w != OCW'(OP_DEPTH));
    assign op_push_w = op_valid && op_ready;
    assign res_valid = (res_count_w != '0);
    assign res_pop_w = res_valid && res_ready;

    // Credit check uses the result occupancy after this cycle's capture and
    // pop, so the op issued now always has a slot when it completes.
    assign capture_w  = add_done && (state_q == BUSY);
    assign res_next_w = res_count_w + RCW'(capture_w) - RCW'(res_pop_w);
    assign issue_w    = add_done && (op_count_w != '0)
                        && (res_next_w < RCW'(RES_DEPTH));

    assign add_a = issue_w ? op_head_w[2*WORDWIDTH-1:WORDWIDTH] : '0;
    assign add_b = issue_w ? op_head_w[WORDWIDTH-1:0]           : '0;

    assign res_wdata_w.cout = add_cout;
    assign res_wdata_w.sum  = add_sum;
    assign res_sum  = res_head_w.sum;
    assign res_cout = res_head_w.cout;

    assign busy = (state_q == BUSY) || (op_count_w != '0) || (res_count_w != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (add_done) begin
            state_q <= issue_w ? BUSY : IDLE;
        end
    end

    serial_seq_fifo #(
        .WIDTH (2*WORDWIDTH),
        .DEPTH (OP_DEPTH)
    ) u_op_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (op_push_w),
        .wdata_i ({op_a, op_b}),
        .pop_i   (issue_w),
        .rdata_o (op_head_w),
        .count_o (op_count_w)
    );

    serial_seq_fifo #(
        .WIDTH (WORDWIDTH+1),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (capture_w),
        .wdata_i (res_wdata_w),
        .pop_i   (res_pop_w),
        .rdata_o (res_head_w),
        .count_o (res_count_w)
    );

`ifdef SERIAL_ADD_SEQ_OVF_EN
    logic ovf_q;

    // Set has priority over a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (capture_w && add_cout) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf_sticky = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_sequencer
// Description : Self-checking bench with a behavioural serial-adder model and
//               an in-order expected-result queue. Honours SERIAL_ADD_SEQ_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_sequencer;
    import serial_add_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned P = add_period(W);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         op_valid, op_ready;
    logic [W-1:0] op_a, op_b;
    logic [W-1:0] add_a, add_b;
    logic         add_done;
    logic [W-1:0] add_sum;
    logic         add_cout;
    logic         res_valid, res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         busy;
`ifdef SERIAL_ADD_SEQ_OVF_EN
    logic         ovf_clr;
    logic         ovf_sticky;
`endif

    serial_add_sequencer #(
        .WORDWIDTH (W),
        .OP_DEPTH  (2),
        .RES_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_done  (add_done),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .busy      (busy)
`ifdef SERIAL_ADD_SEQ_OVF_EN
        ,
        .ovf_clr   (ovf_clr),
        .ovf_sticky(ovf_sticky)
`endif
    );

    always #5 clk = ~clk;

    // Free-running bit-serial adder: samples a/b at each done edge and
    // presents their sum during the next done cycle.
    int unsigned  acnt;
    logic [W-1:0] asum;
    logic         acout;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acnt  <= 0;
            asum  <= '0;
            acout <= 1'b0;
        end else begin
            acnt <= (acnt == P-1) ? 0 : acnt + 1;
            if (acnt == P-1) {acout, asum} <= {1'b0, add_a} + {1'b0, add_b};
        end
    end
    assign add_done = (acnt == P-1);
    assign add_sum  = asum;
    assign add_cout = acout;

    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    int           ndone = 0;
    int           popped = 0;
    int           last_pop = 0;
    bit           have_last = 0;
    bit           chk_rate = 0;
    bit           pushed_now = 0;
    logic [W:0]   expq[$];
    logic         s_done, s_res_valid, s_res_cout, s_op_ready, s_busy;
    logic [W-1:0] s_add_a, s_add_b, s_res_sum;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, update the model on handshakes, return
    // just after the next posedge so the caller can drive new inputs.
    task automatic cycle();
        logic [W:0] expv;
        @(negedge clk);
        #1;
        cyc++;
        s_done = add_done;       s_add_a = add_a;       s_add_b = add_b;
        s_res_valid = res_valid; s_res_sum = res_sum;   s_res_cout = res_cout;
        s_op_ready = op_ready;   s_busy = busy;
        if (add_done) ndone++;
        pushed_now = op_valid && op_ready;
        if (pushed_now) expq.push_back({1'b0, op_a} + {1'b0, op_b});
        if (res_valid && res_ready) begin
            popped++;
            if (expq.size() == 0) begin
                chk("spurious_res_valid", 32'(res_valid), 32'd0);
            end else begin
                expv = expq.pop_front();
                chk("res_data", 32'({res_cout, res_sum}), 32'(expv));
                if (chk_rate && have_last) chk("res_interval", 32'(cyc - last_pop), 32'(P));
                last_pop  = cyc;
                have_last = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b);
        op_valid = 1'b1; op_a = a; op_b = b;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (pushed_now) break;
        end
        chk("push_accepted", 32'(pushed_now), 32'd1);
        op_valid = 1'b0; op_a = '0; op_b = '0;
    endtask

    task automatic drain();
        res_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (expq.size() == 0) break;
            cycle();
        end
        chk("drain_empty", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        int  d0, p0, sent, nz, any_valid;
        bit  acc5;
        logic [W-1:0] ra, rb;

        rst_n = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
`ifdef SERIAL_ADD_SEQ_OVF_EN
        ovf_clr = 1'b0;
`endif
        #1;
        chk("rst_op_ready", 32'(op_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_sum", 32'({res_cout, res_sum}), 32'd0);
        chk("rst_add_ab", 32'({add_a, add_b}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef SERIAL_ADD_SEQ_OVF_EN
        chk("rst_ovf", 32'(ovf_sticky), 32'd0);
`endif
        repeat (3) cycle();
        rst_n = 1'b1;

        // First done after reset must not produce a result.
        any_valid = 0;
        repeat (P + 3) begin
            cycle();
            if (s_res_valid) any_valid++;
        end
        chk("post_reset_done_seen", 32'(ndone >= 1), 32'd1);
        chk("post_reset_no_valid", 32'(any_valid), 32'd0);
        chk("post_reset_busy", 32'(s_busy), 32'd0);

        // Single op: latency and data.
        push_op(8'h5A, 8'h33);
        d0 = ndone;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (s_done && ndone == d0 + 1) begin
                chk("issue_add_a", 32'(s_add_a), 32'h5A);
                chk("issue_add_b", 32'(s_add_b), 32'h33);
            end
            if (ndone == d0 + 2) break;
        end
        chk("second_done_seen", 32'(ndone), 32'(d0 + 2));
        chk("valid_in_capture_cycle", 32'(s_res_valid), 32'd0);
        chk("add_a_idle_done", 32'(s_add_a), 32'd0);
        cycle();
        chk("res_valid_rise", 32'(s_res_valid), 32'd1);
        chk("single_sum", 32'(s_res_sum), 32'h8D);
        chk("single_cout", 32'(s_res_cout), 32'd0);
        drain();
`ifdef SERIAL_ADD_SEQ_OVF_EN
        chk("ovf_clear_before", 32'(ovf_sticky), 32'd0);
`endif

        // Carry out: sum wraps, carry reported separately.
        push_op(8'hFF, 8'h01);
        p0 = popped;
        drain();
        chk("wrap_result_popped", 32'(popped - p0), 32'd1);
`ifdef SERIAL_ADD_SEQ_OVF_EN
        repeat (3) cycle();
        chk("ovf_set", 32'(ovf_sticky), 32'd1);
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        cycle();
        chk("ovf_cleared", 32'(ovf_sticky), 32'd0);
`endif

        // Back-pressure: two results held, two ops queued, fifth op stalls.
        res_ready = 1'b0;
        p0 = popped;
        repeat (4) push_op(8'($urandom), 8'($urandom));
        op_valid = 1'b1; op_a = 8'($urandom); op_b = 8'($urandom);
        acc5 = 1'b0; nz = 0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (pushed_now) begin acc5 = 1'b1; op_valid = 1'b0; end
            if (i >= 30 && s_done && (s_add_a != '0 || s_add_b != '0)) nz++;
        end
        chk("stall_op_ready", 32'(s_op_ready), 32'd0);
        chk("stall_res_valid", 32'(s_res_valid), 32'd1);
        chk("stall_op5_pending", 32'(acc5), 32'd0);
        chk("stall_no_issue", 32'(nz), 32'd0);
        chk("stall_busy", 32'(s_busy), 32'd1);
        res_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (acc5) break;
            cycle();
            if (pushed_now) begin acc5 = 1'b1; op_valid = 1'b0; end
        end
        op_valid = 1'b0;
        chk("op5_accepted", 32'(acc5), 32'd1);
        drain();
        chk("stall_all_results", 32'(popped - p0), 32'd5);

        // Back-to-back random stream at full rate.
        p0 = popped; sent = 0; have_last = 1'b0; chk_rate = 1'b1;
        ra = 8'($urandom); rb = 8'($urandom);
        for (int i = 0; i < 32*P + 80; i++) begin
            op_valid = (sent < 32); op_a = ra; op_b = rb;
            cycle();
            if (pushed_now) begin
                sent++;
                ra = 8'($urandom); rb = 8'($urandom);
            end
            if (sent == 32 && expq.size() == 0) break;
        end
        op_valid = 1'b0; chk_rate = 1'b0;
        chk("stream_sent", 32'(sent), 32'd32);
        chk("stream_results", 32'(popped - p0), 32'd32);

        // Reset mid-operation with buffered ops and results.
        res_ready = 1'b0;
        repeat (4) push_op(8'($urandom), 8'($urandom));
        repeat (3) cycle();
        chk("pre_reset_busy", 32'(s_busy), 32'd1);
        chk("pre_reset_full", 32'(s_op_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_res_valid", 32'(res_valid), 32'd0);
        chk("async_rst_op_ready", 32'(op_ready), 32'd1);
        chk("async_rst_res_data", 32'({res_cout, res_sum}), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_add_ab", 32'({add_a, add_b}), 32'd0);
        expq.delete();
        repeat (2) cycle();
        rst_n = 1'b1;
        res_ready = 1'b1;
        p0 = popped;
        push_op(8'h12, 8'hF0);
        drain();
        repeat (3*P) cycle();
        chk("post_reset_one_result", 32'(popped - p0), 32'd1);
        chk("post_reset_idle", 32'(s_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
